ber_accum: RTL and testbench

//  Bit-error-rate accumulator placed directly downstream of bit_com: consumes the per-frame

---
 rtl/ber_accum.sv | 141 ++++++++++++++
 tb/tb_ber_accum.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_accum.sv
// Bit-error-rate accumulator: sums per-frame Hamming distances over a programmed window of frames.
// Define BER_ACCUM_SAT_EN to saturate bit_err_cnt_o instead of wrapping it.
module ber_accum #(
   parameter int WIN_W = 16,
   parameter int ERR_W = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIN_W-1:0] num_frames_i,
   input  logic             ham_dis_valid_i,
   input  logic [3:0]       ham_dis_i,
   output logic             ham_dis_ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIN_W-1:0] frame_cnt_o,
   output logic [WIN_W-1:0] frame_err_cnt_o,
   output logic [ERR_W-1:0] bit_err_cnt_o,
   output logic [3:0]       max_dis_o,
   output logic             overflow_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] numFrames_q, numFrames_d;
   logic [WIN_W-1:0] frameCnt_q, frameCnt_d;
   logic [WIN_W-1:0] frameErrCnt_q, frameErrCnt_d;
   logic [ERR_W-1:0] bitErrCnt_q, bitErrCnt_d;
   logic [3:0]       maxDis_q, maxDis_d;
   logic             overflow_q, overflow_d;

   logic             accept;
   logic             startAccepted;
   logic             lastFrame;
   logic [ERR_W:0]   bitErrSum;

   assign accept        = ham_dis_valid_i & (state_q == RUN);
   assign startAccepted = start_i & (state_q != RUN);
   assign lastFrame     = (frameCnt_q == numFrames_q - WIN_W'(1));
   assign bitErrSum     = {1'b0, bitErrCnt_q} + {{(ERR_W-3){1'b0}}, ham_dis_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = (num_frames_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept && lastFrame) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o          = (state_q == RUN);
      done_o          = (state_q == DONE);
      ham_dis_ready_o = (state_q == RUN);
   end

   // A carry out of the widened sum is the overflow event in both build variants.
   always_comb begin
      numFrames_d   = numFrames_q;
      frameCnt_d    = frameCnt_q;
      frameErrCnt_d = frameErrCnt_q;
      bitErrCnt_d   = bitErrCnt_q;
      maxDis_d      = maxDis_q;
      overflow_d    = overflow_q;
      if (startAccepted) begin
         numFrames_d   = num_frames_i;
         frameCnt_d    = '0;
         frameErrCnt_d = '0;
         bitErrCnt_d   = '0;
         maxDis_d      = '0;
         overflow_d    = 1'b0;
      end else if (accept) begin
         frameCnt_d = frameCnt_q + WIN_W'(1);
         if (ham_dis_i != 4'd0) begin
            frameErrCnt_d = frameErrCnt_q + WIN_W'(1);
         end
         if (ham_dis_i > maxDis_q) begin
            maxDis_d = ham_dis_i;
         end
`ifdef BER_ACCUM_SAT_EN
         if (bitErrSum[ERR_W]) begin
            bitErrCnt_d = '1;
            overflow_d  = 1'b1;
         end else begin
            bitErrCnt_d = bitErrSum[ERR_W-1:0];
         end
`else
         bitErrCnt_d = bitErrSum[ERR_W-1:0];
         if (bitErrSum[ERR_W]) begin
            overflow_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         numFrames_q   <= '0;
         frameCnt_q    <= '0;
         frameErrCnt_q <= '0;
         bitErrCnt_q   <= '0;
         maxDis_q      <= '0;
         overflow_q    <= 1'b0;
      end else begin
         numFrames_q   <= numFrames_d;
         frameCnt_q    <= frameCnt_d;
         frameErrCnt_q <= frameErrCnt_d;
         bitErrCnt_q   <= bitErrCnt_d;
         maxDis_q      <= maxDis_d;
         overflow_q    <= overflow_d;
      end
   end

   assign frame_cnt_o     = frameCnt_q;
   assign frame_err_cnt_o = frameErrCnt_q;
   assign bit_err_cnt_o   = bitErrCnt_q;
   assign max_dis_o       = maxDis_q;
   assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_ber_accum.sv
// Directed self-checking bench for ber_accum; a second instance with ERR_W=4 exercises overflow.
module tb_ber_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] numFrames;
   logic        hamValid;
   logic [3:0]  hamDis;

   logic        ready, busy, done, overflow;
   logic [15:0] frameCnt, frameErrCnt;
   logic [19:0] bitErrCnt;
   logic [3:0]  maxDis;

   logic        smReady, smBusy, smDone, smOverflow;
   logic [15:0] smFrameCnt, smFrameErrCnt;
   logic [3:0]  smBitErrCnt;
   logic [3:0]  smMaxDis;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   ber_accum #(.WIN_W(16), .ERR_W(20)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .num_frames_i(numFrames),
      .ham_dis_valid_i(hamValid), .ham_dis_i(hamDis), .ham_dis_ready_o(ready),
      .busy_o(busy), .done_o(done), .frame_cnt_o(frameCnt), .frame_err_cnt_o(frameErrCnt),
      .bit_err_cnt_o(bitErrCnt), .max_dis_o(maxDis), .overflow_o(overflow)
   );

   ber_accum #(.WIN_W(16), .ERR_W(4)) dutSmall (
      .clk_i(clk), .rst_i(rst), .start_i(start), .num_frames_i(numFrames),
      .ham_dis_valid_i(hamValid), .ham_dis_i(hamDis), .ham_dis_ready_o(smReady),
      .busy_o(smBusy), .done_o(smDone), .frame_cnt_o(smFrameCnt), .frame_err_cnt_o(smFrameErrCnt),
      .bit_err_cnt_o(smBitErrCnt), .max_dis_o(smMaxDis), .overflow_o(smOverflow)
   );

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; numFrames = '0; hamValid = 1'b0; hamDis = '0;
      step();
      rst = 1'b0;
      nCompared++;
      if ({ready, busy, done, overflow} !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_flags got %b want 0000", {ready, busy, done, overflow});
      end
      nCompared++;
      if ({frameCnt, frameErrCnt, bitErrCnt, maxDis} !== 56'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_counts got %0d/%0d/%0d/%0d want 0/0/0/0",
                  frameCnt, frameErrCnt, bitErrCnt, maxDis);
      end
      hamValid = 1'b1; hamDis = 4'd5;
      step(); step();
      hamValid = 1'b0;
      nCompared++;
      if ({frameCnt, bitErrCnt, maxDis, busy, done} !== 42'd0) begin
         nMismatched++;
         $display("[TB] FAIL idle_drop got frame=%0d bit=%0d max=%0d busy=%b done=%b want all 0",
                  frameCnt, bitErrCnt, maxDis, busy, done);
      end
   endtask

   task automatic test_window();
      start = 1'b1; numFrames = 16'd4;
      step();
      start = 1'b0;
      nCompared++;
      if ({busy, ready, done} !== 3'b110) begin
         nMismatched++;
         $display("[TB] FAIL window_enter got busy/ready/done=%b want 110", {busy, ready, done});
      end
      hamValid = 1'b1;
      hamDis = 4'd0; step();
      hamDis = 4'd1; step();
      hamDis = 4'd3; step();
      nCompared++;
      if ({done, frameCnt} !== {1'b0, 16'd3}) begin
         nMismatched++;
         $display("[TB] FAIL window_third got done=%b frame=%0d want 0/3", done, frameCnt);
      end
      hamDis = 4'd0; step();
      nCompared++;
      if ({done, busy, ready} !== 3'b100) begin
         nMismatched++;
         $display("[TB] FAIL window_done got done/busy/ready=%b want 100", {done, busy, ready});
      end
      nCompared++;
      if ({frameCnt, frameErrCnt, bitErrCnt, maxDis} !== {16'd4, 16'd2, 20'd4, 4'd3}) begin
         nMismatched++;
         $display("[TB] FAIL window_counts got frame=%0d ferr=%0d bit=%0d max=%0d want 4/2/4/3",
                  frameCnt, frameErrCnt, bitErrCnt, maxDis);
      end
      hamDis = 4'd7; step();
      hamValid = 1'b0;
      nCompared++;
      if ({frameCnt, bitErrCnt, maxDis, done} !== {16'd4, 20'd4, 4'd3, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL window_fifth_drop got frame=%0d bit=%0d max=%0d done=%b want 4/4/3/1",
                  frameCnt, bitErrCnt, maxDis, done);
      end
   endtask

   task automatic test_zero_window();
      start = 1'b1; numFrames = 16'd0;
      step();
      start = 1'b0;
      nCompared++;
      if ({done, busy} !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL zero_done got done/busy=%b want 10", {done, busy});
      end
      nCompared++;
      if ({frameCnt, frameErrCnt, bitErrCnt, maxDis} !== 56'd0) begin
         nMismatched++;
         $display("[TB] FAIL zero_counts got %0d/%0d/%0d/%0d want 0/0/0/0",
                  frameCnt, frameErrCnt, bitErrCnt, maxDis);
      end
      step();
      nCompared++;
      if ({done, busy} !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL zero_hold got done/busy=%b want 10", {done, busy});
      end
   endtask

   task automatic test_gaps_stray_start();
      start = 1'b1; numFrames = 16'd3;
      step();
      start = 1'b0; numFrames = 16'd9;
      hamValid = 1'b1; hamDis = 4'd2; step();
      hamValid = 1'b0; hamDis = 4'd9; step(); step();
      nCompared++;
      if ({frameCnt, bitErrCnt} !== {16'd1, 20'd2}) begin
         nMismatched++;
         $display("[TB] FAIL gaps_hold got frame=%0d bit=%0d want 1/2", frameCnt, bitErrCnt);
      end
      hamValid = 1'b1; hamDis = 4'd5; start = 1'b1; numFrames = 16'd1; step();
      start = 1'b0; hamValid = 1'b0; step();
      nCompared++;
      if ({busy, frameCnt, bitErrCnt} !== {1'b1, 16'd2, 20'd7}) begin
         nMismatched++;
         $display("[TB] FAIL stray_start got busy=%b frame=%0d bit=%0d want 1/2/7",
                  busy, frameCnt, bitErrCnt);
      end
      hamValid = 1'b1; hamDis = 4'd1; step();
      hamValid = 1'b0;
      nCompared++;
      if ({done, frameCnt, frameErrCnt, bitErrCnt, maxDis} !== {1'b1, 16'd3, 16'd3, 20'd8, 4'd5}) begin
         nMismatched++;
         $display("[TB] FAIL gaps_counts got done=%b frame=%0d ferr=%0d bit=%0d max=%0d want 1/3/3/8/5",
                  done, frameCnt, frameErrCnt, bitErrCnt, maxDis);
      end
      start = 1'b1; numFrames = 16'd2; step();
      start = 1'b0;
      nCompared++;
      if ({busy, done, frameCnt, frameErrCnt, bitErrCnt, maxDis} !== {2'b10, 56'd0}) begin
         nMismatched++;
         $display("[TB] FAIL restart_clear got busy=%b done=%b frame=%0d ferr=%0d bit=%0d max=%0d want 1/0/0/0/0/0",
                  busy, done, frameCnt, frameErrCnt, bitErrCnt, maxDis);
      end
   endtask

   task automatic test_overflow();
      logic [3:0] expBit;
`ifdef BER_ACCUM_SAT_EN
      expBit = 4'd15;
`else
      expBit = 4'd8;
`endif
      rst = 1'b1; step();
      rst = 1'b0;
      start = 1'b1; numFrames = 16'd2; step();
      start = 1'b0;
      hamValid = 1'b1; hamDis = 4'd12; step();
      nCompared++;
      if ({smBitErrCnt, smOverflow} !== {4'd12, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL ovf_first got bit=%0d ovf=%b want 12/0", smBitErrCnt, smOverflow);
      end
      step();
      hamValid = 1'b0;
      nCompared++;
      if ({smBitErrCnt, smOverflow, smDone} !== {expBit, 2'b11}) begin
         nMismatched++;
         $display("[TB] FAIL ovf_small got bit=%0d ovf=%b done=%b want %0d/1/1",
                  smBitErrCnt, smOverflow, smDone, expBit);
      end
      nCompared++;
      if ({bitErrCnt, overflow, maxDis, frameErrCnt} !== {20'd24, 1'b0, 4'd12, 16'd2}) begin
         nMismatched++;
         $display("[TB] FAIL ovf_wide got bit=%0d ovf=%b max=%0d ferr=%0d want 24/0/12/2",
                  bitErrCnt, overflow, maxDis, frameErrCnt);
      end
      start = 1'b1; numFrames = 16'd1; step();
      start = 1'b0;
      nCompared++;
      if ({smOverflow, smBitErrCnt} !== 5'd0) begin
         nMismatched++;
         $display("[TB] FAIL ovf_clear got ovf=%b bit=%0d want 0/0", smOverflow, smBitErrCnt);
      end
      hamValid = 1'b1; hamDis = 4'd15; step();
      hamValid = 1'b0;
      nCompared++;
      if ({maxDis, bitErrCnt, frameErrCnt, done} !== {4'd15, 20'd15, 16'd1, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL unfiltered_15 got max=%0d bit=%0d ferr=%0d done=%b want 15/15/1/1",
                  maxDis, bitErrCnt, frameErrCnt, done);
      end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1; numFrames = 16'd10; step();
      start = 1'b0;
      hamValid = 1'b1;
      hamDis = 4'd1; step();
      hamDis = 4'd2; step();
      hamDis = 4'd3; step();
      nCompared++;
      if ({busy, frameCnt, bitErrCnt} !== {1'b1, 16'd3, 20'd6}) begin
         nMismatched++;
         $display("[TB] FAIL midrun_partial got busy=%b frame=%0d bit=%0d want 1/3/6",
                  busy, frameCnt, bitErrCnt);
      end
      rst = 1'b1; start = 1'b1; step();
      rst = 1'b0; start = 1'b0;
      nCompared++;
      if ({ready, busy, done, overflow, frameCnt, frameErrCnt, bitErrCnt, maxDis} !== 60'd0) begin
         nMismatched++;
         $display("[TB] FAIL midrun_reset got rdy=%b busy=%b done=%b frame=%0d bit=%0d max=%0d want all 0",
                  ready, busy, done, frameCnt, bitErrCnt, maxDis);
      end
      step();
      hamValid = 1'b0;
      nCompared++;
      if ({busy, frameCnt, bitErrCnt} !== 37'd0) begin
         nMismatched++;
         $display("[TB] FAIL midrun_after got busy=%b frame=%0d bit=%0d want 0/0/0",
                  busy, frameCnt, bitErrCnt);
      end
   endtask

   initial begin
      test_reset();
      test_window();
      test_zero_window();
      test_gaps_stray_start();
      test_overflow();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
